irrigation_zone_scheduler: RTL and testbench



---
 rtl/irrigation_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/irrigation_zone_scheduler.sv | 165 ++++++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared state encoding and default limits for the irrigation zone scheduler
// Contents:
//   state_t        : scheduler FSM states (3-bit)
//   FULL_LEVEL_DEF : tank level treated as full
//   MAX_WAIT_DEF   : cycles allowed in a waiting state before FAULT
//   WAIT_W         : width of the wait counter
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        DRAIN  = 3'd2,
        REFILL = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam int FULL_LEVEL_DEF = 7;
    localparam int MAX_WAIT_DEF   = 31;
    localparam int WAIT_W         = 5;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among eligible zones
// Ports:
//   req   : eligible request vector (pending & enable)
//   ptr   : zone index with highest priority this round
//   grant : one-hot winner (zero when nothing is eligible)
//   valid : a winner exists
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [PW:0] idx;

    // Walk the zones starting at ptr, wrapping at N; the first requester wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = {1'b0, ptr} + (PW+1)'(off);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!valid && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// rtl/irrigation_zone_scheduler.sv - shares one water tank between zones, sequencing fill/drain per zone
// Ports:
//   Ctrl_clk    : controller clock
//   reset       : asynchronous active-low reset
//   zone_req    : per-zone watering request (level or pulse)
//   zone_enable : per-zone mask; disabled zones never queue or win
//   fault_clr   : pulse that leaves FAULT
//   nivel       : current tank level from the tank controller
//   Esvaziar    : tank controller is emptying
//   start_fill  : to tank controller, 1 = fill / return to filling
//   valve       : one-hot zone valve enable
//   zone_done   : one-cycle pulse when a zone's watering completes
//   busy        : scheduler not idle
//   fault       : scheduler in FAULT
module irrigation_zone_scheduler
    import irrigation_pkg::*;
#(
    parameter int NUM_ZONES  = 4,
    parameter int LEVEL_W    = 3,
    parameter int FULL_LEVEL = FULL_LEVEL_DEF,
    parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
    input  logic                 Ctrl_clk,
    input  logic                 reset,
    input  logic [NUM_ZONES-1:0] zone_req,
    input  logic [NUM_ZONES-1:0] zone_enable,
    input  logic                 fault_clr,
    input  logic [LEVEL_W-1:0]   nivel,
    input  logic                 Esvaziar,
    output logic                 start_fill,
    output logic [NUM_ZONES-1:0] valve,
    output logic [NUM_ZONES-1:0] zone_done,
    output logic                 busy,
    output logic                 fault
);

    localparam int PW = $clog2(NUM_ZONES);

    state_t               state, state_nxt;
    logic [NUM_ZONES-1:0] pending, pending_nxt;
    logic [NUM_ZONES-1:0] grant, grant_nxt;
    logic [NUM_ZONES-1:0] eligible, arb_grant;
    logic                 arb_valid;
    logic [PW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
    logic                 wait_expired;
    logic                 tank_full;
    logic                 start_fill_nxt, busy_nxt, fault_nxt;
    logic [NUM_ZONES-1:0] valve_nxt, done_nxt;

    // The clear for a finished zone is taken while zone_done is high, so a
    // request seen in that same cycle re-queues the zone (set wins). The
    // finishing zone is also kept out of arbitration for that one cycle.
    assign pending_nxt  = ((pending & ~zone_done) | zone_req) & zone_enable;
    assign eligible     = pending & zone_enable & ~zone_done;
    assign tank_full    = (nivel == LEVEL_W'(FULL_LEVEL));
    // Fires on the cycle the counter would reach MAX_WAIT.
    assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    rr_arbiter #(
        .N  (NUM_ZONES),
        .PW (PW)
    ) u_rr_arbiter (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        done_nxt     = '0;
        wait_cnt_nxt = wait_cnt + 1'b1;

        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (arb_valid && tank_full) begin
                    grant_nxt = arb_grant;
                    state_nxt = GRANT;
                    for (int i = 0; i < NUM_ZONES; i++) begin
                        if (arb_grant[i]) begin
                            rr_ptr_nxt = (i == NUM_ZONES - 1) ? '0 : PW'(i + 1);
                        end
                    end
                end
            end
            GRANT: begin
                if (Esvaziar) begin
                    state_nxt = DRAIN;
                end else if (wait_expired) begin
                    state_nxt = FAULT;
                end
            end
            DRAIN: begin
                if (nivel == '0) begin
                    state_nxt = REFILL;
                end else if (wait_expired) begin
                    state_nxt = FAULT;
                end
            end
            REFILL: begin
                if (!Esvaziar) begin
                    done_nxt  = grant;
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end else if (wait_expired) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                wait_cnt_nxt = '0;
                if (fault_clr) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Aborted zone stays pending and is retried after fault_clr.
        if (state_nxt == FAULT) begin
            grant_nxt = '0;
        end
        if (state_nxt != state) begin
            wait_cnt_nxt = '0;
        end

        // Outputs are registered, so derive them from the next state.
        start_fill_nxt = !((state_nxt == GRANT) || (state_nxt == DRAIN));
        valve_nxt      = (state_nxt == DRAIN) ? grant_nxt : '0;
        busy_nxt       = (state_nxt != IDLE);
        fault_nxt      = (state_nxt == FAULT);
    end

    always_ff @(posedge Ctrl_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pending    <= '0;
            grant      <= '0;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            start_fill <= 1'b1;
            valve      <= '0;
            zone_done  <= '0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            grant      <= grant_nxt;
            rr_ptr     <= rr_ptr_nxt;
            wait_cnt   <= wait_cnt_nxt;
            start_fill <= start_fill_nxt;
            valve      <= valve_nxt;
            zone_done  <= done_nxt;
            busy       <= busy_nxt;
            fault      <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb/tb_irrigation_zone_scheduler.sv - scoreboard bench for irrigation_zone_scheduler with a behavioural tank
module tb_irrigation_zone_scheduler;

    logic       Ctrl_clk;
    logic       reset;
    logic [3:0] zone_req;
    logic [3:0] zone_enable;
    logic       fault_clr;
    logic [2:0] nivel;
    logic       Esvaziar;
    logic       start_fill;
    logic [3:0] valve;
    logic [3:0] zone_done;
    logic       busy;
    logic       fault;

    logic       tank_rst;
    logic       stuck;
    logic [3:0] prev_valve;
    int         n_checks;
    int         n_fail;
    int         exp_q[$];
    int         cyc;

    irrigation_zone_scheduler #(
        .NUM_ZONES  (4),
        .LEVEL_W    (3),
        .FULL_LEVEL (7),
        .MAX_WAIT   (31)
    ) dut (
        .Ctrl_clk    (Ctrl_clk),
        .reset       (reset),
        .zone_req    (zone_req),
        .zone_enable (zone_enable),
        .fault_clr   (fault_clr),
        .nivel       (nivel),
        .Esvaziar    (Esvaziar),
        .start_fill  (start_fill),
        .valve       (valve),
        .zone_done   (zone_done),
        .busy        (busy),
        .fault       (fault)
    );

    initial begin
        Ctrl_clk = 1'b0;
        forever #5 Ctrl_clk = ~Ctrl_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // Tank controller model: empties while start_fill is low (unless stuck),
    // fills otherwise; one level step per cycle.
    always @(posedge Ctrl_clk) begin
        if (tank_rst) begin
            nivel    <= 3'd0;
            Esvaziar <= 1'b0;
        end else begin
            Esvaziar <= !start_fill && !stuck;
            if (Esvaziar) begin
                if (nivel != 3'd0) nivel <= nivel - 3'd1;
            end else if (nivel != 3'd7) begin
                nivel <= nivel + 3'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: valve openings are compared against the head of the
    // expected-zone queue, and every zone_done pulse pops it.
    always @(negedge Ctrl_clk) begin
        check("valve_onehot", 32'($countones(valve) <= 1), 32'd1);
        check("valve_with_fill", 32'((valve != 4'd0) && start_fill), 32'd0);
        if (valve != 4'd0 && prev_valve == 4'd0) begin
            if (exp_q.size() == 0) check("valve_unexpected", 32'(valve), 32'd0);
            else check("valve_zone", 32'(valve), 32'(1) << exp_q[0]);
        end
        if (zone_done != 4'd0) begin
            if (exp_q.size() == 0) check("done_unexpected", 32'(zone_done), 32'd0);
            else check("zone_done", 32'(zone_done), 32'(1) << exp_q.pop_front());
        end
        prev_valve = valve;
    end

    task automatic do_reset();
        reset    = 1'b0;
        tank_rst = 1'b1;
        zone_req = 4'd0;
        repeat (2) @(negedge Ctrl_clk);
        reset    = 1'b1;
        tank_rst = 1'b0;
    endtask

    task automatic wait_full(input string tag);
        for (int i = 0; i < 60 && nivel != 3'd7; i++) @(negedge Ctrl_clk);
        check(tag, 32'(nivel), 32'd7);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge Ctrl_clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_req(input logic [3:0] r);
        zone_req = r;
        @(negedge Ctrl_clk);
        zone_req = 4'd0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        prev_valve  = 4'd0;
        reset       = 1'b0;
        tank_rst    = 1'b1;
        stuck       = 1'b0;
        zone_req    = 4'd0;
        zone_enable = 4'hF;
        fault_clr   = 1'b0;
        repeat (3) @(negedge Ctrl_clk);
        check("rst_start_fill", 32'(start_fill), 32'd1);
        check("rst_valve", 32'(valve), 32'd0);
        check("rst_zone_done", 32'(zone_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset    = 1'b1;
        tank_rst = 1'b0;

        // 1: single request while tank is empty waits for full level
        exp_q.push_back(0);
        pulse_req(4'b0001);
        repeat (3) @(negedge Ctrl_clk);
        check("t1_idle_not_full", 32'(busy), 32'd0);
        for (cyc = 0; cyc < 40 && !busy; cyc++) @(negedge Ctrl_clk);
        check("t1_level_at_grant", 32'(nivel), 32'd7);
        check("t1_grant_fill_low", 32'(start_fill), 32'd0);
        wait_empty("t1_served", 100);
        @(negedge Ctrl_clk);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: all zones at once are served 0,1,2,3
        do_reset();
        wait_full("t2_full");
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        pulse_req(4'b1111);
        wait_empty("t2_served", 400);

        // 3: zone 2 re-requests during its zone_done pulse
        do_reset();
        wait_full("t3_full");
        exp_q.push_back(2);
        exp_q.push_back(3);
        pulse_req(4'b1100);
        for (cyc = 0; cyc < 200 && zone_done != 4'b0100; cyc++) @(negedge Ctrl_clk);
        check("t3_done2_seen", 32'(zone_done), 32'b0100);
        zone_req = 4'b0101;
        exp_q.push_back(0);
        exp_q.push_back(2);
        @(negedge Ctrl_clk);
        zone_req = 4'd0;
        wait_empty("t3_served", 400);

        // 4: tank never empties -> FAULT after 31 cycles in GRANT, then retry
        do_reset();
        stuck = 1'b1;
        wait_full("t4_full");
        pulse_req(4'b0010);
        for (cyc = 0; cyc < 40 && start_fill; cyc++) @(negedge Ctrl_clk);
        check("t4_grant_seen", 32'(start_fill), 32'd0);
        cyc = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge Ctrl_clk);
            if (fault) break;
            cyc++;
        end
        check("t4_grant_cycles", 32'(cyc), 32'd31);
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_fault_valve", 32'(valve), 32'd0);
        check("t4_fault_fill", 32'(start_fill), 32'd1);
        check("t4_fault_busy", 32'(busy), 32'd1);
        stuck = 1'b0;
        exp_q.push_back(1);
        fault_clr = 1'b1;
        @(negedge Ctrl_clk);
        fault_clr = 1'b0;
        check("t4_fault_cleared", 32'(fault), 32'd0);
        wait_empty("t4_retry", 100);

        // 5: disabled zone never queues, even after it is enabled
        do_reset();
        zone_enable = 4'b1011;
        wait_full("t5_full");
        pulse_req(4'b0100);
        repeat (20) @(negedge Ctrl_clk);
        check("t5_masked_busy", 32'(busy), 32'd0);
        zone_enable = 4'b1111;
        repeat (20) @(negedge Ctrl_clk);
        check("t5_enabled_busy", 32'(busy), 32'd0);

        // 6: reset during DRAIN closes the valve at once and loses the queue
        do_reset();
        wait_full("t6_full");
        exp_q.push_back(1);
        pulse_req(4'b0010);
        for (cyc = 0; cyc < 40 && valve == 4'd0; cyc++) @(negedge Ctrl_clk);
        check("t6_drain_valve", 32'(valve), 32'b0010);
        reset = 1'b0;
        #1;
        check("t6_async_valve", 32'(valve), 32'd0);
        check("t6_async_fill", 32'(start_fill), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge Ctrl_clk);
        reset = 1'b1;
        repeat (30) @(negedge Ctrl_clk);
        check("t6_busy_after", 32'(busy), 32'd0);
        check("t6_done_after", 32'(zone_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
